// File: rtl/decoder_onehot_seq_if.sv
// decoder_onehot_seq_if: select stream in, one-hot word stream out, plus mode/enable controls
interface decoder_onehot_seq_if #(
   parameter int SEL_W = 3
);
   localparam int OUTS = 2 ** SEL_W;
   logic             en;
   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic             out_valid;
   logic             out_ready;
   logic [OUTS-1:0]  onehot;
   logic [SEL_W-1:0] idx;
   logic             wrap;
   modport master (
      output en, mode, in_valid, sel, out_ready,
      input  in_ready, out_valid, onehot, idx, wrap
   );
   modport slave (
      input  en, mode, in_valid, sel, out_ready,
      output in_ready, out_valid, onehot, idx, wrap
   );
endinterface

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered N-to-2^N one-hot decoder with a walking-token scan mode
module decoder_onehot_seq #(
   parameter int SEL_W      = 3,
   parameter bit ACTIVE_LOW = 1'b0,
   parameter int SCAN_START = 0
) (
   input logic                  clk,
   input logic                  rst,
   decoder_onehot_seq_if.slave  bus
);
   localparam int OUTS = 2 ** SEL_W;
   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
   state_t           state_q;
   logic [SEL_W-1:0] idx_q;
   logic             out_valid_q;
   logic             wrap_q;
   logic             accept;
   logic [OUTS-1:0]  dec;
   // Only plain DECODE states take new codes; a mode change or scan never accepts.
   assign bus.in_ready = ~rst & bus.en & ~bus.mode & (state_q != SCAN) & (~out_valid_q | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;
   assign dec          = out_valid_q ? (OUTS'(1) << idx_q) : '0;
   assign bus.onehot   = ACTIVE_LOW ? ~dec : dec;
   assign bus.idx      = idx_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wrap     = wrap_q & bus.en;
   // Decode/hold/scan state machine; en low freezes everything except the wrap pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else if (!bus.en) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (state_q == SCAN) begin
            if (!bus.mode) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end else if (bus.out_ready) begin
               idx_q  <= idx_q + 1'b1;
               wrap_q <= &idx_q;
            end
         end else if (bus.mode) begin
            state_q     <= SCAN;
            idx_q       <= SEL_W'(SCAN_START);
            out_valid_q <= 1'b1;
         end else if (accept) begin
            state_q     <= HOLD;
            idx_q       <= bus.sel;
            out_valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb_decoder_onehot_seq: table, directed and randomized checks of decoder_onehot_seq
module tb_decoder_onehot_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   decoder_onehot_seq_if #(.SEL_W(3)) ia ();
   decoder_onehot_seq_if #(.SEL_W(3)) ib ();
   decoder_onehot_seq_if #(.SEL_W(1)) ic ();
   decoder_onehot_seq #(.SEL_W(3), .ACTIVE_LOW(1'b0), .SCAN_START(6)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   decoder_onehot_seq #(.SEL_W(3), .ACTIVE_LOW(1'b1), .SCAN_START(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   decoder_onehot_seq #(.SEL_W(1), .ACTIVE_LOW(1'b0), .SCAN_START(0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

   typedef struct {
      bit v;
      bit scan;
      int idx;
      bit wrap;
   } mstate_t;

   typedef struct {
      bit iv;
      int sel;
      bit ordy;
      bit exp_rdy;
      bit exp_v;
      int exp_oh;
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural reference: what the next observable word is, given the rules.
   function automatic mstate_t mnext(mstate_t s, bit en, bit mode, bit iv, bit ordy, int sel, int start, int outs);
      mstate_t n = s;
      n.wrap = 1'b0;
      if (!en) return n;
      if (s.scan) begin
         if (!mode) begin
            n.scan = 1'b0;
            n.v    = 1'b0;
         end else if (ordy) begin
            n.idx  = (s.idx + 1) % outs;
            n.wrap = (n.idx == 0);
         end
      end else if (mode) begin
         n.scan = 1'b1;
         n.v    = 1'b1;
         n.idx  = start;
      end else if (iv && (!s.v || ordy)) begin
         n.v   = 1'b1;
         n.idx = sel;
      end else if (ordy) begin
         n.v = 1'b0;
      end
      return n;
   endfunction

   function automatic logic [63:0] exp_oh(mstate_t s, int outs, bit al);
      logic [63:0] m = (64'd1 << outs) - 64'd1;
      logic [63:0] w = s.v ? (64'd1 << s.idx) : 64'd0;
      return al ? (~w & m) : w;
   endfunction

   initial begin
      vec_t    tv [9];
      int      c_sel [4];
      int      c_exp [4];
      mstate_t ma, mb;
      bit      en, mode, iv, ordy;
      int      sel;
      tv[0] = '{1, 3, 1, 1, 1, 'h08};
      tv[1] = '{1, 6, 1, 1, 1, 'h40};
      tv[2] = '{1, 2, 1, 1, 1, 'h04};
      tv[3] = '{0, 0, 0, 0, 1, 'h04};
      tv[4] = '{1, 5, 0, 0, 1, 'h04};
      tv[5] = '{1, 5, 0, 0, 1, 'h04};
      tv[6] = '{1, 5, 0, 0, 1, 'h04};
      tv[7] = '{0, 0, 1, 1, 0, 'h00};
      tv[8] = '{1, 1, 0, 1, 1, 'h02};
      c_sel = '{0, 1, 0, 1};
      c_exp = '{1, 2, 1, 2};
      {ia.en, ia.mode, ia.in_valid, ia.sel, ia.out_ready} = '0;
      {ib.en, ib.mode, ib.in_valid, ib.sel, ib.out_ready} = '0;
      {ic.en, ic.mode, ic.in_valid, ic.sel, ic.out_ready} = '0;
      tick;
      tick;
      chk("rst_ready_a", 64'(ia.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("reset_oh_a", 64'(ia.onehot), 64'h00);
      chk("reset_oh_b", 64'(ib.onehot), 64'hFF);
      chk("reset_valid_a", 64'(ia.out_valid), 64'd0);
      chk("reset_idx_a", 64'(ia.idx), 64'd0);
      tick;
      ia.en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ia.in_valid  = tv[i].iv;
         ia.sel       = 3'(tv[i].sel);
         ia.out_ready = tv[i].ordy;
         #1;
         chk($sformatf("tbl%0d_ready", i), 64'(ia.in_ready), 64'(tv[i].exp_rdy));
         tick;
         chk($sformatf("tbl%0d_valid", i), 64'(ia.out_valid), 64'(tv[i].exp_v));
         chk($sformatf("tbl%0d_onehot", i), 64'(ia.onehot), 64'(tv[i].exp_oh));
      end
      ia.mode = 1'b1; ia.in_valid = 1'b1; ia.sel = 3'd0; ia.out_ready = 1'b1;
      tick;
      chk("scan_enter_idx", 64'(ia.idx), 64'd6);
      chk("scan_ready", 64'(ia.in_ready), 64'd0);
      chk("scan_wrap6", 64'(ia.wrap), 64'd0);
      tick;
      chk("scan_idx7", 64'(ia.idx), 64'd7);
      chk("scan_wrap7", 64'(ia.wrap), 64'd0);
      tick;
      chk("scan_idx0", 64'(ia.idx), 64'd0);
      chk("scan_wrap0", 64'(ia.wrap), 64'd1);
      chk("scan_oh0", 64'(ia.onehot), 64'h01);
      tick;
      chk("scan_idx1", 64'(ia.idx), 64'd1);
      chk("scan_wrap1", 64'(ia.wrap), 64'd0);
      ia.out_ready = 1'b0;
      tick;
      tick;
      chk("scan_stall_idx", 64'(ia.idx), 64'd1);
      chk("scan_stall_wrap", 64'(ia.wrap), 64'd0);
      ia.out_ready = 1'b1;
      repeat (4) tick;
      chk("scan_idx5", 64'(ia.idx), 64'd5);
      rst = 1'b1;
      #1;
      chk("async_rst_oh", 64'(ia.onehot), 64'h00);
      chk("async_rst_valid", 64'(ia.out_valid), 64'd0);
      chk("async_rst_idx", 64'(ia.idx), 64'd0);
      chk("async_rst_ready", 64'(ia.in_ready), 64'd0);
      tick;
      rst = 1'b0;
      ia.mode = 1'b1; ia.in_valid = 1'b0;
      tick;
      tick;
      chk("leave_pre_idx", 64'(ia.idx), 64'd7);
      ia.mode = 1'b0; ia.in_valid = 1'b1; ia.sel = 3'd3;
      #1;
      chk("leave_ready", 64'(ia.in_ready), 64'd0);
      tick;
      chk("leave_valid", 64'(ia.out_valid), 64'd0);
      chk("leave_idx", 64'(ia.idx), 64'd7);
      chk("leave_oh", 64'(ia.onehot), 64'h00);
      ia.in_valid = 1'b0;
      ib.en = 1'b1; ib.in_valid = 1'b1; ib.sel = 3'd1; ib.out_ready = 1'b0;
      tick;
      chk("al_oh", 64'(ib.onehot), 64'hFD);
      ib.en = 1'b0; ib.sel = 3'd4; ib.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("freeze%0d_oh", i), 64'(ib.onehot), 64'hFD);
         chk($sformatf("freeze%0d_valid", i), 64'(ib.out_valid), 64'd1);
         chk($sformatf("freeze%0d_idx", i), 64'(ib.idx), 64'd1);
         chk($sformatf("freeze%0d_ready", i), 64'(ib.in_ready), 64'd0);
      end
      ib.en = 1'b1; ib.in_valid = 1'b0;
      tick;
      chk("al_drain_valid", 64'(ib.out_valid), 64'd0);
      chk("al_drain_oh", 64'(ib.onehot), 64'hFF);
      ic.en = 1'b1; ic.in_valid = 1'b1; ic.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ic.sel = 1'(c_sel[i]);
         tick;
         chk($sformatf("w1_%0d_oh", i), 64'(ic.onehot), 64'(c_exp[i]));
      end
      rst = 1'b1;
      {ia.en, ia.mode, ia.in_valid, ia.sel, ia.out_ready} = '0;
      {ib.en, ib.mode, ib.in_valid, ib.sel, ib.out_ready} = '0;
      tick;
      rst = 1'b0;
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
      mode = 1'b0;
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(9) != 0);
         if ($urandom_range(9) == 0) mode = ~mode;
         iv   = 1'($urandom);
         sel  = int'($urandom_range(7));
         ordy = ($urandom_range(9) < 7);
         ia.en = en; ia.mode = mode; ia.in_valid = iv; ia.sel = 3'(sel); ia.out_ready = ordy;
         ib.en = en; ib.mode = mode; ib.in_valid = iv; ib.sel = 3'(sel); ib.out_ready = ordy;
         #1;
         chk("rnd_ready_a", 64'(ia.in_ready), 64'(en && !mode && !ma.scan && (!ma.v || ordy)));
         chk("rnd_ready_b", 64'(ib.in_ready), 64'(en && !mode && !mb.scan && (!mb.v || ordy)));
         chk("rnd_wrap_a", 64'(ia.wrap), 64'(ma.wrap && en));
         ma = mnext(ma, en, mode, iv, ordy, sel, 6, 8);
         mb = mnext(mb, en, mode, iv, ordy, sel, 0, 8);
         tick;
         chk("rnd_valid_a", 64'(ia.out_valid), 64'(ma.v));
         chk("rnd_oh_a", 64'(ia.onehot), exp_oh(ma, 8, 1'b0));
         chk("rnd_oh_b", 64'(ib.onehot), exp_oh(mb, 8, 1'b1));
         chk("rnd_wrap_b", 64'(ib.wrap), 64'(mb.wrap && en));
         if (ma.v) chk("rnd_idx_a", 64'(ia.idx), 64'(ma.idx));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
